regfile_dump_reader: RTL and testbench

//  Read-side companion to RegisterFile_32Bit. On a start pulse, sweeps both read ports
//  (AddrA/AddrB) over registers 0..NUM_REGS-1, two per read cycle.

---
 rtl/regfile_dump_reader_pkg.sv | 20 ++
 rtl/regfile_dump_reader.sv | 154 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths
// (matching RegisterFile_32Bit) and the sweep FSM state encoding.
package regfile_dump_reader_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EMIT_A = 3'd2,
    ST_EMIT_B = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic is_emit(input state_e s);
    return (s == ST_EMIT_A) || (s == ST_EMIT_B);
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Sweeps both register-file read ports over regs 0..NUM_REGS-1, two per read
// cycle, and streams each register as an {addr,data} beat on a valid/ready port.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] AddrA,
  output logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  // One extra pointer bit so ptr+2 cannot wrap when NUM_REGS == 2**ADDR_W
  localparam logic [ADDR_W:0] LP_NUM = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LP_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LP_TWO = (ADDR_W+1)'(2);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   w_ptr_nxt;
  logic [ADDR_W:0]   w_ptr_p1;
  logic [ADDR_W:0]   w_ptr_p2;
  logic [ADDR_W:0]   w_nptr_p1;
  logic [DATA_W-1:0] r_bufB;
  logic [DATA_W-1:0] w_bufB_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addrA;
  logic [ADDR_W-1:0] r_addrB;
  logic [ADDR_W-1:0] r_oaddr;
  logic [DATA_W-1:0] r_odata;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_valid_nxt;
  logic [ADDR_W-1:0] w_addrA_nxt;
  logic [ADDR_W-1:0] w_addrB_nxt;
  logic [ADDR_W-1:0] w_oaddr_nxt;
  logic [DATA_W-1:0] w_odata_nxt;
  logic              w_hs;

  assign w_hs      = r_valid & out_ready;
  assign w_ptr_p1  = r_ptr + LP_ONE;
  assign w_ptr_p2  = r_ptr + LP_TWO;
  assign w_nptr_p1 = w_ptr_nxt + LP_ONE;

  assign busy      = r_busy;
  assign done      = r_done;
  assign AddrA     = r_addrA;
  assign AddrB     = r_addrB;
  assign out_valid = r_valid;
  assign out_addr  = r_oaddr;
  assign out_data  = r_odata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_bufB  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_addrA <= '0;
      r_addrB <= '0;
      r_oaddr <= '0;
      r_odata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_bufB  <= w_bufB_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_addrA <= w_addrA_nxt;
      r_addrB <= w_addrB_nxt;
      r_oaddr <= w_oaddr_nxt;
      r_odata <= w_odata_nxt;
    end
  end

  // Abort wins over everything, including a handshake in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (r_state != ST_IDLE && abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_state_nxt = ST_READ;
            w_ptr_nxt   = '0;
          end
        end
        ST_READ:   w_state_nxt = ST_EMIT_A;
        ST_EMIT_A: begin
          if (w_hs) w_state_nxt = (w_ptr_p1 == LP_NUM) ? ST_DONE : ST_EMIT_B;
        end
        ST_EMIT_B: begin
          if (w_hs) begin
            if (w_ptr_p2 >= LP_NUM) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_READ;
              w_ptr_nxt   = w_ptr_p2;
            end
          end
        end
        ST_DONE:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are computed from the upcoming state so they can be registered
  always_comb begin
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_valid_nxt = is_emit(w_state_nxt);
    w_addrA_nxt = r_addrA;
    w_addrB_nxt = r_addrB;
    w_oaddr_nxt = r_oaddr;
    w_odata_nxt = r_odata;
    w_bufB_nxt  = r_bufB;
    if (w_state_nxt == ST_READ) begin
      w_addrA_nxt = w_ptr_nxt[ADDR_W-1:0];
      w_addrB_nxt = (w_nptr_p1 == LP_NUM) ? w_ptr_nxt[ADDR_W-1:0] : w_nptr_p1[ADDR_W-1:0];
    end
    if (r_state == ST_READ && w_state_nxt == ST_EMIT_A) begin
      w_oaddr_nxt = r_ptr[ADDR_W-1:0];
      w_odata_nxt = DataA;
      w_bufB_nxt  = DataB;
    end
    if (r_state == ST_EMIT_A && w_state_nxt == ST_EMIT_B) begin
      w_oaddr_nxt = w_ptr_p1[ADDR_W-1:0];
      w_odata_nxt = r_bufB;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: a 32-register and a 5-register reader share stimulus;
// beats are compared against an in-bench register array and ordered index model.
module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    string name;
    logic  sel;
    int    readyMode;
    int    extraStart;
    int    expBeats;
    int    expDones;
    int    expFirst;
    int    expDoneLat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, out_ready, curSel;
  logic start32, start5;
  logic busy32, done32, valid32, busy5, done5, valid5;
  logic [AW-1:0] addrA32, addrB32, oaddr32, addrA5, addrB5, oaddr5;
  logic [DW-1:0] dataA32, dataB32, odata32, dataA5, dataB5, odata5;
  logic [DW-1:0] regs32 [32];
  logic [DW-1:0] regs5  [32];

  logic busy, done, valid;
  logic [AW-1:0] oaddr, addrA, addrB;
  logic [DW-1:0] odata;

  int nVectors = 0;
  int nMiscompares = 0;

  assign start32 = start & ~curSel;
  assign start5  = start & curSel;
  assign dataA32 = regs32[addrA32];
  assign dataB32 = regs32[addrB32];
  assign dataA5  = regs5[addrA5];
  assign dataB5  = regs5[addrB5];

  assign busy  = curSel ? busy5  : busy32;
  assign done  = curSel ? done5  : done32;
  assign valid = curSel ? valid5 : valid32;
  assign oaddr = curSel ? oaddr5 : oaddr32;
  assign odata = curSel ? odata5 : odata32;
  assign addrA = curSel ? addrA5 : addrA32;
  assign addrB = curSel ? addrB5 : addrB32;

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort),
    .busy(busy32), .done(done32), .AddrA(addrA32), .AddrB(addrB32),
    .DataA(dataA32), .DataB(dataB32), .out_valid(valid32), .out_ready(out_ready),
    .out_addr(oaddr32), .out_data(odata32)
  );

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort),
    .busy(busy5), .done(done5), .AddrA(addrA5), .AddrB(addrB5),
    .DataA(dataA5), .DataB(dataB5), .out_valid(valid5), .out_ready(out_ready),
    .out_addr(oaddr5), .out_data(odata5)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] expData(input logic sel, input int idx);
    return sel ? regs5[idx] : regs32[idx];
  endfunction

  // Runs one dump; -1 disables the extra-start, abort and reset injections
  task automatic applyStimulus(input logic sel, input int readyMode, input int extraStart,
                               input int abortBeat, input int rstBeat,
                               output int beats, output int dones,
                               output int firstLat, output int doneLat);
    int n, c;
    logic prevStall, hs, finished;
    logic [AW-1:0] prevAddr;
    logic [DW-1:0] prevData;
    n = sel ? 5 : 32;
    beats = 0; dones = 0; firstLat = -1; doneLat = -1;
    prevStall = 1'b0; prevAddr = '0; prevData = '0; finished = 1'b0;
    @(negedge clk);
    curSel = sel; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    c = 0;
    while (!finished) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      abort = 1'b0;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (prevStall)
        checkOutput("stall_hold", 64'({valid, oaddr, odata}), 64'({1'b1, prevAddr, prevData}));
      if (done) begin
        dones++;
        doneLat = c;
      end
      if (valid && beats == extraStart) start = 1'b1;
      if (valid && beats == abortBeat) begin
        abort = 1'b1;
        out_ready = 1'b1;
      end
      if (valid && beats == rstBeat) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs",
                       64'({busy, done, valid, oaddr, odata, addrA, addrB}), 64'(0));
        rst_n = 1'b1;
        finished = 1'b1;
      end else begin
        hs = valid && out_ready && !abort;
        if (hs) begin
          if (beats == 0) firstLat = c;
          checkOutput("beat_addr", 64'(oaddr), 64'(beats));
          checkOutput("beat_data", 64'(odata), 64'(expData(sel, beats)));
          if (beats % 2 == 0)
            checkOutput("read_addrs", 64'({addrA, addrB}),
                        64'({AW'(beats), AW'((beats + 1 == n) ? beats : beats + 1)}));
          beats++;
        end
        prevStall = valid && !out_ready && !abort;
        prevAddr  = oaddr;
        prevData  = odata;
        if (c > 1 && !busy) finished = 1'b1;
        if (c > 600) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL timeout: dump still busy after %0d cycles, expected idle", c);
          finished = 1'b1;
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkCleanDump(input string name);
    int b, d, f, dl;
    applyStimulus(1'b0, 0, -1, -1, -1, b, d, f, dl);
    checkOutput({name, "_beats"}, 64'(b), 64'(32));
    checkOutput({name, "_dones"}, 64'(d), 64'(1));
    checkOutput({name, "_first_latency"}, 64'(f), 64'(2));
    checkOutput({name, "_done_latency"}, 64'(dl), 64'(49));
  endtask

  initial begin
    vec_t vecs[7];
    int b, d, f, dl;
    logic sawDone;

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; curSel = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs32[i] = DW'(i * 3);
      regs5[i]  = DW'(32'hA0 + i);
    end

    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset_state32", 64'({busy32, done32, valid32, oaddr32, odata32, addrA32, addrB32}), 64'(0));
    checkOutput("reset_state5",  64'({busy5, done5, valid5, oaddr5, odata5, addrA5, addrB5}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_with_abort_ignored", 64'(busy32), 64'(0));

    vecs[0] = '{"full_ready",      1'b0, 0, -1, 32, 1,  2, 49};
    vecs[1] = '{"full_stall_100",  1'b0, 1, -1, 32, 1, -1, -1};
    vecs[2] = '{"odd5_ready",      1'b1, 0, -1,  5, 1,  2,  9};
    vecs[3] = '{"restart_ignored", 1'b0, 0,  7, 32, 1,  2, 49};
    vecs[4] = '{"full_random",     1'b0, 2, -1, 32, 1, -1, -1};
    vecs[5] = '{"odd5_random",     1'b1, 2, -1,  5, 1, -1, -1};
    vecs[6] = '{"odd5_stall_100",  1'b1, 1, -1,  5, 1, -1, -1};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].readyMode == 2) begin
        for (int i = 0; i < 32; i++) begin
          if (vecs[v].sel) regs5[i] = $urandom;
          else             regs32[i] = $urandom;
        end
      end
      applyStimulus(vecs[v].sel, vecs[v].readyMode, vecs[v].extraStart, -1, -1, b, d, f, dl);
      checkOutput({vecs[v].name, "_beats"}, 64'(b), 64'(vecs[v].expBeats));
      checkOutput({vecs[v].name, "_dones"}, 64'(d), 64'(vecs[v].expDones));
      if (vecs[v].expFirst >= 0)
        checkOutput({vecs[v].name, "_first_latency"}, 64'(f), 64'(vecs[v].expFirst));
      if (vecs[v].expDoneLat >= 0)
        checkOutput({vecs[v].name, "_done_latency"}, 64'(dl), 64'(vecs[v].expDoneLat));
      repeat (2) @(negedge clk);
      checkOutput({vecs[v].name, "_idle_after"}, 64'({busy, valid, done}), 64'(0));
    end

    // Abort while addr 9 is pending, with ready high to show abort beats the handshake
    applyStimulus(1'b0, 0, -1, 9, -1, b, d, f, dl);
    checkOutput("abort_beats", 64'(b), 64'(9));
    checkOutput("abort_dones", 64'(d), 64'(0));
    checkOutput("abort_outputs", 64'({busy, valid}), 64'(0));
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_late_done", 64'(sawDone), 64'(0));
    checkCleanDump("after_abort");

    // Short reset pulse between clock edges at beat 12
    applyStimulus(1'b0, 1, -1, -1, 12, b, d, f, dl);
    checkOutput("reset_beats", 64'(b), 64'(12));
    @(negedge clk);
    checkOutput("reset_still_idle", 64'({busy, valid}), 64'(0));
    checkCleanDump("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
